// File: rtl/cg_ctrl_multi.sv
// Multi-channel clock-gating controller: per-channel idle timer, gate/wake FSM and latch-based glitch-free gate.
// Optional per-channel gated-cycle statistics are built when CG_STATS_EN is defined.
module cg_ctrl_multi #(
  parameter int NUM_CH      = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_en,
  input  logic [IDLE_W-1:0]      idle_thresh,
  input  logic [NUM_CH-1:0]      busy,
  input  logic [NUM_CH-1:0]      force_on,
  input  logic                   test_en,
  input  logic                   stats_clr,
  output logic [NUM_CH-1:0]      gclk,
  output logic [NUM_CH-1:0]      ch_ready,
  output logic [NUM_CH-1:0]      ch_gated,
  output logic [NUM_CH*16-1:0]   gated_cycles
);

  // state | meaning
  // RUN   | clock running, channel active
  // COUNT | clock running, counting consecutive idle edges
  // GATED | clock stopped
  // WAKE  | clock restarted, waiting for it to settle before ready
  typedef enum logic [1:0] {S_RUN, S_COUNT, S_GATED, S_WAKE} state_t;

  localparam logic [3:0] WAKE_CNT = 4'(WAKE_CYCLES);

`ifndef CG_STATS_EN
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_t            state_q, state_d;
    logic [IDLE_W-1:0] cnt_q, cnt_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic              en_q, en_d;
    logic              ready_q, ready_d;
    logic              gated_q, gated_d;
    logic              lat_en;
    logic              wake;

    assign wake = busy[g] | force_on[g] | ~cfg_en;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      case (state_q)
        S_RUN: begin
          if (!wake && idle_thresh != '0) begin
            state_d = S_COUNT;
            cnt_d   = IDLE_W'(1);
          end
        end
        S_COUNT: begin
          if (wake || idle_thresh == '0) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else if (cnt_q >= idle_thresh) begin
            state_d = S_GATED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GATED: begin
          if (wake) begin
            state_d = S_WAKE;
            wcnt_d  = 4'd1;
          end
        end
        S_WAKE: begin
          // wake dropping here is ignored; the restart always completes
          if (wcnt_q >= WAKE_CNT) begin
            state_d = S_RUN;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
        default: state_d = S_RUN;
      endcase
      en_d    = (state_d != S_GATED);
      ready_d = (state_d == S_RUN) || (state_d == S_COUNT);
      gated_d = (state_d == S_GATED);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_RUN;
        cnt_q   <= '0;
        wcnt_q  <= '0;
        en_q    <= 1'b1;
        ready_q <= 1'b0;
        gated_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        wcnt_q  <= wcnt_d;
        en_q    <= en_d;
        ready_q <= ready_d;
        gated_q <= gated_d;
      end
    end

    // Enable only moves while clk is low, so gclk can never be chopped mid-pulse.
    always_latch begin
      if (rst)
        lat_en = 1'b1;
      else if (!clk)
        lat_en = en_q | test_en;
    end

    assign gclk[g]     = clk & lat_en;
    assign ch_ready[g] = ready_q;
    assign ch_gated[g] = gated_q;

`ifdef CG_STATS_EN
    logic [15:0] stat_q, stat_d;

    always_comb begin
      stat_d = stat_q;
      if (stats_clr)
        stat_d = '0;
      else if (state_q == S_GATED && stat_q != 16'hFFFF)
        stat_d = stat_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) stat_q <= '0;
      else     stat_q <= stat_d;
    end

    assign gated_cycles[g*16 +: 16] = stat_q;
`else
    assign gated_cycles[g*16 +: 16] = 16'h0000;
`endif
  end

endmodule

// File: tb/tb_cg_ctrl_multi.sv
// Directed self-checking bench for cg_ctrl_multi (NUM_CH=4, IDLE_W=8, WAKE_CYCLES=2).
module tb_cg_ctrl_multi;
  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [7:0]  idle_thresh;
  logic [3:0]  busy;
  logic [3:0]  force_on;
  logic        test_en;
  logic        stats_clr;
  logic [3:0]  gclk;
  logic [3:0]  ch_ready;
  logic [3:0]  ch_gated;
  logic [63:0] gated_cycles;

  int n_cmp = 0;
  int n_err = 0;
  int glitches = 0;
  bit mon_on = 1'b0;

  cg_ctrl_multi #(.NUM_CH(4), .IDLE_W(8), .WAKE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .idle_thresh(idle_thresh),
    .busy(busy), .force_on(force_on), .test_en(test_en), .stats_clr(stats_clr),
    .gclk(gclk), .ch_ready(ch_ready), .ch_gated(ch_gated), .gated_cycles(gated_cycles)
  );

  always #5 clk = ~clk;

  // gclk[2] may only rise together with clk (posedges at 5 mod 10)
  always @(posedge gclk[2]) if (mon_on && ($time % 10) != 5) glitches++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1; cfg_en = 1'b1; idle_thresh = 8'd3; busy = 4'hF;
    force_on = 4'h0; test_en = 1'b0; stats_clr = 1'b0;

    // reset state
    tick(2);
    check("rst_gclk", gclk, 4'hF);
    check("rst_ready", ch_ready, 4'h0);
    check("rst_gated", ch_gated, 4'h0);
    check("rst_stats", gated_cycles, 64'h0);
    rst = 1'b0;
    #2;
    check("rel_ready_before_edge", ch_ready, 4'h0);
    tick(1);
    check("rel_ready_after_edge", ch_ready, 4'hF);

    // gate ch0 with threshold 3: busy drops before E1
    busy = 4'hE;
    tick(3);
    check("e3_gated", ch_gated, 4'h0);
    check("e3_gclk", gclk, 4'hF);
    tick(1);
    check("e4_gclk_pulse", gclk, 4'hF);
    check("e4_gated", ch_gated, 4'h1);
    check("e4_ready", ch_ready, 4'hE);
    tick(1);
    check("e5_gclk_suppressed", gclk, 4'hE);
`ifdef CG_STATS_EN
    check("e5_stats", gated_cycles[15:0], 16'd1);
`else
    check("e5_stats_tied", gated_cycles, 64'h0);
`endif

    // async reset while ch0 gated (clk high right now)
    rst = 1'b1;
    #1;
    check("rstmid_gclk_now", gclk, 4'hF);
    check("rstmid_gated", ch_gated, 4'h0);
    check("rstmid_ready", ch_ready, 4'h0);
    tick(1);
    check("rstmid_ready_hold", ch_ready, 4'h0);
    rst = 1'b0;
    tick(1);
    check("rstmid_ready_rel", ch_ready, 4'hF);
    check("rstmid_stats", gated_cycles, 64'h0);

    // wake with a 1-cycle busy pulse
    tick(4);
    check("wk_pre_gated", ch_gated, 4'h1);
    tick(2);
    busy = 4'hF;
    tick(1);  // edge N
    check("wk_n_gclk", gclk, 4'hE);
    check("wk_n_gated", ch_gated, 4'h0);
    check("wk_n_ready", ch_ready, 4'hE);
    busy = 4'hE;
    tick(1);  // N+1
    check("wk_n1_gclk", gclk, 4'hF);
    check("wk_n1_ready", ch_ready, 4'hE);
    tick(1);  // N+2
    check("wk_n2_ready", ch_ready, 4'hF);

    // regate, then statistics
    tick(4);
    check("rg_gated", ch_gated, 4'h1);
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    check("st_clr_prio", gated_cycles[15:0], 16'd0);
    tick(10);
`ifdef CG_STATS_EN
    check("st_ten", gated_cycles[15:0], 16'd10);
    check("st_others", gated_cycles[63:16], 48'h0);
    repeat (65525) @(posedge clk);
    #1;
    check("st_sat", gated_cycles[15:0], 16'hFFFF);
    tick(5);
    check("st_sat_hold", gated_cycles[15:0], 16'hFFFF);
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
    check("st_clr", gated_cycles[15:0], 16'd0);
`else
    check("st_tied", gated_cycles, 64'h0);
`endif

    // threshold lowered mid-COUNT: cnt already above new value
    idle_thresh = 8'd8; busy = 4'hF;
    do_reset();
    busy = 4'h0;
    tick(5);
    check("th_e5_gated", ch_gated, 4'h0);
    idle_thresh = 8'd3;
    tick(1);
    check("th_e6_gated", ch_gated, 4'hF);

    // overrides
    busy = 4'hF;
    do_reset();
    busy = 4'h0; force_on = 4'h2;
    tick(6);
    check("fo_gated", ch_gated, 4'hD);
    check("fo_gclk", gclk, 4'h2);
    cfg_en = 1'b0;
    tick(1);
    check("cfg_n_gated", ch_gated, 4'h0);
    check("cfg_n_ready", ch_ready, 4'h2);
    tick(1);
    check("cfg_n1_ready", ch_ready, 4'h2);
    tick(1);
    check("cfg_n2_ready", ch_ready, 4'hF);
    tick(6);
    check("cfg_off_nogate", ch_gated, 4'h0);
    cfg_en = 1'b1; force_on = 4'h0; idle_thresh = 8'd0;
    tick(12);
    check("th0_nogate", ch_gated, 4'h0);
    check("th0_gclk", gclk, 4'hF);

    // DFT bypass
    idle_thresh = 8'd3;
    tick(5);
    check("dft_pre_gated", ch_gated, 4'hF);
    mon_on = 1'b1;
    test_en = 1'b1;
    tick(1);
    check("dft_gclk_on", gclk, 4'hF);
    check("dft_gated_kept", ch_gated, 4'hF);
    tick(2);
    test_en = 1'b0;
    tick(1);
    check("dft_gclk_off", gclk, 4'h0);
    check("dft_gated_after", ch_gated, 4'hF);
    tick(3);
    mon_on = 1'b0;
    check("dft_glitch", glitches, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
